// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the sequential signed multiplier.
// The default operand width and its matching shift-add iteration count.
package mul_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int ITER_COUNT    = DEFAULT_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add the (pre-shifted) multiplicand
// magnitude to the running accumulator.
module mul_step
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic               mbit,
    output logic [2*WIDTH-1:0] acc_out
);

    always_comb begin
        // NOTE: default first so every path assigns acc_out and no latch is inferred.
        acc_out = acc_in;
        if (mbit) begin
            acc_out = acc_in + mcand;
        end
    end

endmodule

// File: rtl/seq_signed_multiplier.sv
// Sign-magnitude sequential multiplier: WIDTH shift-add cycles on operand
// magnitudes, then a single fix-up cycle restores the product sign.
module seq_signed_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

    state_t              state;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  acc_next;
    logic [2*WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]    mplier;
    logic [CNT_W-1:0]    cnt;
    logic                neg;

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc),
        .mcand   (mcand),
        .mbit    (mplier[0]),
        .acc_out (acc_next)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            P      <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, magnitude(A)};
                        mplier <= magnitude(B);
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= A[WIDTH-1] ^ B[WIDTH-1];
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // Multiplicand walks left while multiplier bits are consumed LSB-first.
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    P     <= neg ? -acc : acc;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed bench for seq_signed_multiplier: expected products are queued at
// launch and compared when done pulses.
module tb_seq_signed_multiplier;
    import mul_pkg::*;

    localparam int W       = 32;
    localparam int LATENCY = ITER_COUNT + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          busy;
    logic          done;
    logic [2*W-1:0] P;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] sb[$];

    seq_signed_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint x;
        longint y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    // Present a request on the next falling edge and queue its product.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        sb.push_back(model(a, b));
    endtask

    // Half a cycle after the accepting edge: drop start and scramble operands.
    task automatic accept(input string tag);
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        check({tag, ":busy_after_accept"}, 64'(busy), 64'd1);
    endtask

    // Count edges until done; first_edge is how many edges past acceptance have passed.
    task automatic await_done(input string tag, input int first_edge);
        int           edges;
        logic [63:0]  p_entry;
        logic [63:0]  expected;
        bit           p_moved;
        edges   = first_edge;
        p_entry = P;
        p_moved = 1'b0;
        while (done !== 1'b1 && edges < first_edge + 100) begin
            @(negedge clk);
            edges++;
            if (done !== 1'b1 && P !== p_entry) p_moved = 1'b1;
        end
        check({tag, ":latency"}, 64'(edges), 64'(LATENCY));
        check({tag, ":P_held_until_fix"}, 64'(p_moved), 64'd0);
        expected = (sb.size() != 0) ? sb.pop_front() : 'x;
        check({tag, ":P"}, P, expected);
        @(negedge clk);
        check({tag, ":done_one_cycle"}, 64'(done), 64'd0);
        check({tag, ":idle_after_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        launch(a, b);
        accept(tag);
        await_done(tag, 0);
    endtask

    initial begin
        int          pulses;
        logic [63:0] last_p;

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        check("reset:busy", 64'(busy), 64'd0);
        check("reset:done", 64'(done), 64'd0);
        check("reset:P", P, 64'd0);
        rst = 1'b0;

        run_op("7x-3", 32'd7, 32'hFFFF_FFFD);
        run_op("min_x_min", 32'h8000_0000, 32'h8000_0000);
        run_op("max_x_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op("m1_x_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("zero_x_m5", 32'd0, 32'hFFFF_FFFB);
        run_op("min_x_one", 32'h8000_0000, 32'd1);
        run_op("pos_x_neg", 32'd123_456, 32'hFFF0_BDC0);

        last_p = P;
        repeat (5) @(negedge clk);
        check("hold:P_between_ops", P, last_p);

        // A second start arriving while busy must be dropped.
        launch(32'h0001_2345, 32'hFFFF_FF00);
        accept("repulse");
        repeat (9) @(negedge clk);
        A     = 32'd99;
        B     = 32'd77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        await_done("repulse", 10);
        last_p = P;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("repulse:no_second_done", 64'(pulses), 64'd0);
        check("repulse:P_unchanged", P, last_p);

        // Reset in the middle of CALC aborts without a done pulse.
        launch(32'd1000, 32'd3000);
        accept("abort");
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort:busy", 64'(busy), 64'd0);
        check("abort:done", 64'(done), 64'd0);
        check("abort:P", P, 64'd0);
        sb.delete();
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort:no_done", 64'(pulses), 64'd0);
        run_op("after_abort", 32'hFFFF_FFF6, 32'd12);

        // start held high across two operations.
        launch(32'd6, 32'hFFFF_FFF9);
        @(negedge clk);
        check("b2b:first_busy", 64'(busy), 64'd1);
        A = 32'h0000_4000;
        B = 32'h0000_0300;
        sb.push_back(model(32'h0000_4000, 32'h0000_0300));
        last_p = P;
        await_done("b2b_first", 0);
        check("b2b:idle_P_holds_first", P, model(32'd6, 32'hFFFF_FFF9));
        accept("b2b_second");
        await_done("b2b_second", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
